lms_adapt_ctrl: RTL and testbench
=================================

Name: lms_adapt_ctrl

Overview:
Sequencer for the LMS weight-update datapath. It converts a sample-rate strobe into the datapath's clk_en/enable pair and schedules step_size, starting at a programmed value and halving it (step-size annealing) while the error stays small. It monitors block-averaged |e|, freezes adaptation once converged, and restarts training if the error grows. It sits between the sample front-end and the LMS datapath.

Parameters:
DATA_WIDTH, 16, width of e, step_size, mu_init, mu_min, thresh and block_err.
BLOCK_LEN, 64, samples per error-averaging block; power of 2, ≥2.
CONV_BLOCKS, 4, consecutive good blocks required to declare convergence; ≥1.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  pulse; begin training (accepted only in IDLE)
stop  in  1  pulse; abort to IDLE from any state
sample_valid  in  1  one-cycle strobe; e is valid in the same cycle
e  in  DATA_WIDTH signed  current error sample
mu_init  in  DATA_WIDTH signed  initial step size; positive, Q1.(DW-1)
mu_min  in  DATA_WIDTH signed  step-size floor; 0 < mu_min ≤ mu_init
thresh  in  DATA_WIDTH unsigned  convergence threshold on block-mean |e|
clk_en  out  1  datapath clock-enable pulse
adapt_en  out  1  datapath enable (weight update and x shift)
step_size  out  DATA_WIDTH signed  step size to datapath
block_err  out  DATA_WIDTH unsigned  mean |e| of the last completed block
converged  out  1  high in FROZEN
state  out  2  0=IDLE, 1=ADAPT, 2=FROZEN

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; all outputs 0; accumulator, sample counter and good_cnt cleared. This applies from any state, including mid-block.
- IDLE:
  - clk_en=0, adapt_en=0, step_size=0; sample_valid is ignored.
  - start → ADAPT on the next cycle, with step_size=mu_init and acc/count/good_cnt=0.
- Sample path (ADAPT and FROZEN):
  - sample_valid at cycle t → clk_en=1 at t+1 only.
  - |e| is added to acc at t+1. |−2^(DW−1)| saturates to 2^(DW−1)−1.
  - acc width is DW−1+log2(BLOCK_LEN); it cannot overflow.
  - Back-to-back sample_valid is legal.
- Block evaluation:
  - When the BLOCK_LEN-th sample is accumulated (visible at t+1), evaluation is combinational in that cycle and registered at t+2.
  - block_err = acc >> log2(BLOCK_LEN). acc and count restart with no lost samples; a sample arriving at t+1 belongs to the new block.
  - The clk_en at t+1 uses the old step_size and state. New values are visible from t+2.
- ADAPT:
  - adapt_en=1.
  - Good block (block_err < thresh): good_cnt++ and step_size = max(step_size>>>1, mu_min).
  - Otherwise good_cnt=0 and step_size is unchanged.
  - If good_cnt reaches CONV_BLOCKS → FROZEN, with converged=1, adapt_en=0 and step_size held.
- FROZEN:
  - clk_en keeps pulsing; adapt_en=0; monitoring continues.
  - block_err > 2*thresh (compared at DW+1 bits) → ADAPT with step_size=mu_init, good_cnt=0, converged=0.
  - Otherwise stay in FROZEN.
- stop: takes priority over start, sample handling and block evaluation. Next cycle is IDLE with all outputs 0 and acc/count/good_cnt cleared. A pending clk_en pulse is suppressed.
- start outside IDLE is ignored. start and stop in the same cycle → IDLE.
- mu_init, mu_min and thresh are sampled live. Changing them outside IDLE is unsupported.

Test Plan:
(DW=16, BLOCK_LEN=4, CONV_BLOCKS=2, mu_init=0x4000, mu_min=0x0800, thresh=100 unless stated)

1. Reset, then sample_valid ×3 in IDLE → clk_en stays 0; all outputs 0; state=0.
2. start, then 8 samples e=+10,−10,… → clk_en one cycle after each strobe. After block 1: block_err=10, step_size=0x2000. After block 2: step_size=0x1000, state=2, converged=1, adapt_en=0 from t+2.
3. mu_init=0x1000, CONV_BLOCKS=4, 3 good blocks → step_size goes 0x0800, 0x0800, 0x0800 (floor holds); state stays ADAPT.
4. Blocks good, bad (e=500), good → step_size 0x2000, 0x2000, 0x1000; good_cnt=1; no freeze.
5. From FROZEN, block of e=300 → block_err=300>200 → state=1, step_size=0x4000, converged=0. A block of e=150 instead → stays FROZEN.
6. Edge cases:
   - Block of e=−32768 ×4 → block_err=32767.
   - stop after 2 samples → IDLE next cycle; after restart, the first block averages only new samples.
   - rst_n low mid-block → identical to test 1.

Source files
------------

// File: rtl/lms_adapt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lms_adapt_ctrl
// Description : LMS adaptation sequencer. It turns sample strobes into
//               datapath enables, anneals the step size, and freezes or
//               retrains from block-averaged |e|.
// Revision    : 1.0 - initial release
// ============================================================================
module lms_adapt_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int BLOCK_LEN   = 64,
    parameter int CONV_BLOCKS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         sample_valid,
    input  logic signed [DATA_WIDTH-1:0] e,
    input  logic signed [DATA_WIDTH-1:0] mu_init,
    input  logic signed [DATA_WIDTH-1:0] mu_min,
    input  logic        [DATA_WIDTH-1:0] thresh,
    output logic                         clk_en,
    output logic                         adapt_en,
    output logic signed [DATA_WIDTH-1:0] step_size,
    output logic        [DATA_WIDTH-1:0] block_err,
    output logic                         converged,
    output logic        [1:0]            state
);

    localparam int c_log2_bl = $clog2(BLOCK_LEN);
    localparam int c_acc_w   = DATA_WIDTH - 1 + c_log2_bl;
    localparam int c_cnt_w   = c_log2_bl + 1;
    localparam int c_good_w  = $clog2(CONV_BLOCKS + 1);

    localparam logic [c_cnt_w-1:0]  c_block_len = c_cnt_w'(BLOCK_LEN);
    localparam logic [c_good_w-1:0] c_conv      = c_good_w'(CONV_BLOCKS);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_adapt  = 2'd1;
    localparam logic [1:0] c_st_frozen = 2'd2;

    logic [1:0]                  r_state;
    logic [1:0]                  w_state_nxt;
    logic                        r_clk_en;
    logic [c_acc_w-1:0]          r_acc;
    logic [c_cnt_w-1:0]          r_cnt;
    logic                        r_blk_full;
    logic [c_good_w-1:0]         r_good;
    logic signed [DATA_WIDTH-1:0] r_step;
    logic [DATA_WIDTH-1:0]       r_blk_err;

    logic [DATA_WIDTH-1:0]       w_neg_e;
    logic [DATA_WIDTH-2:0]       w_abs_e;
    logic [c_acc_w-1:0]          w_acc_base;
    logic [c_acc_w-1:0]          w_acc_sum;
    logic [c_cnt_w-1:0]          w_cnt_base;
    logic [c_cnt_w-1:0]          w_cnt_inc;
    logic [DATA_WIDTH-1:0]       w_blk_err_new;
    logic                        w_good;
    logic                        w_restart;
    logic [c_good_w-1:0]         w_good_inc;
    logic signed [DATA_WIDTH-1:0] w_half;
    logic signed [DATA_WIDTH-1:0] w_step_ann;

    // |e| with the most negative code saturated to the largest positive one
    assign w_neg_e = -e;
    always_comb begin
        w_abs_e = e[DATA_WIDTH-2:0];
        if (e[DATA_WIDTH-1]) begin
            if (e == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
                w_abs_e = '1;
            end else begin
                w_abs_e = w_neg_e[DATA_WIDTH-2:0];
            end
        end
    end

    // A full accumulator is being evaluated this cycle, so a new sample starts the next block
    assign w_acc_base    = r_blk_full ? '0 : r_acc;
    assign w_cnt_base    = r_blk_full ? '0 : r_cnt;
    assign w_cnt_inc     = w_cnt_base + 1'b1;
    assign w_acc_sum     = w_acc_base + {{c_log2_bl{1'b0}}, w_abs_e};
    assign w_blk_err_new = {1'b0, r_acc[c_acc_w-1:c_log2_bl]};
    assign w_good        = (w_blk_err_new < thresh);
    assign w_restart     = ({1'b0, w_blk_err_new} > {thresh, 1'b0});
    assign w_good_inc    = r_good + 1'b1;
    assign w_half        = r_step >>> 1;
    assign w_step_ann    = (w_half < mu_min) ? mu_min : w_half;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) w_state_nxt = c_st_adapt;
            end
            c_st_adapt: begin
                if (r_blk_full && w_good && (w_good_inc >= c_conv)) w_state_nxt = c_st_frozen;
            end
            c_st_frozen: begin
                if (r_blk_full && w_restart) w_state_nxt = c_st_adapt;
            end
            default: w_state_nxt = c_st_idle;
        endcase
        if (stop) w_state_nxt = c_st_idle;
    end

    always_comb begin
        state     = r_state;
        adapt_en  = (r_state == c_st_adapt);
        converged = (r_state == c_st_frozen);
        clk_en    = r_clk_en;
        step_size = r_step;
        block_err = r_blk_err;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || stop) begin
            r_clk_en   <= 1'b0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_blk_full <= 1'b0;
            r_good     <= '0;
            r_step     <= '0;
            r_blk_err  <= '0;
        end else if (r_state == c_st_idle) begin
            r_clk_en   <= 1'b0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_blk_full <= 1'b0;
            r_good     <= '0;
            if (start) r_step <= mu_init;
        end else begin
            r_clk_en <= sample_valid;
            if (sample_valid) begin
                r_acc      <= w_acc_sum;
                r_cnt      <= w_cnt_inc;
                r_blk_full <= (w_cnt_inc == c_block_len);
            end else begin
                r_acc      <= w_acc_base;
                r_cnt      <= w_cnt_base;
                r_blk_full <= 1'b0;
            end
            if (r_blk_full) begin
                r_blk_err <= w_blk_err_new;
                if (r_state == c_st_adapt) begin
                    if (w_good) begin
                        r_good <= w_good_inc;
                        r_step <= w_step_ann;
                    end else begin
                        r_good <= '0;
                    end
                end else if (w_restart) begin
                    r_good <= '0;
                    r_step <= mu_init;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lms_adapt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lms_adapt_ctrl
// Description : Directed and randomized checks of lms_adapt_ctrl against a
//               block-level reference model (two instances, CONV_BLOCKS 2 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lms_adapt_ctrl;

    localparam int c_dw = 16;
    localparam int c_bl = 4;

    logic clk = 1'b0;
    logic rst_n, start, stop, sample_valid;
    logic signed [c_dw-1:0] e, mu_init, mu_min;
    logic [c_dw-1:0] thresh;

    logic [1:0]      clk_en_v, adapt_en_v, conv_v;
    logic [c_dw-1:0] step_v  [2];
    logic [c_dw-1:0] berr_v  [2];
    logic [1:0]      state_v [2];

    int conv_blocks [2] = '{2, 4};

    always #5 clk = ~clk;

    lms_adapt_ctrl #(.DATA_WIDTH(c_dw), .BLOCK_LEN(c_bl), .CONV_BLOCKS(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .sample_valid(sample_valid), .e(e), .mu_init(mu_init), .mu_min(mu_min),
        .thresh(thresh), .clk_en(clk_en_v[0]), .adapt_en(adapt_en_v[0]),
        .step_size(step_v[0]), .block_err(berr_v[0]), .converged(conv_v[0]),
        .state(state_v[0])
    );

    lms_adapt_ctrl #(.DATA_WIDTH(c_dw), .BLOCK_LEN(c_bl), .CONV_BLOCKS(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .sample_valid(sample_valid), .e(e), .mu_init(mu_init), .mu_min(mu_min),
        .thresh(thresh), .clk_en(clk_en_v[1]), .adapt_en(adapt_en_v[1]),
        .step_size(step_v[1]), .block_err(berr_v[1]), .converged(conv_v[1]),
        .state(state_v[1])
    );

    int n_pass  = 0;
    int n_total = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else n_pass++;
    endtask

    // Reference model: a block is a list of |e| values; its mean drives the decision one cycle later
    int m_state [2];
    int m_step  [2];
    int m_berr  [2];
    int m_good  [2];
    int m_clken [2];
    int m_blk   [2][$];
    int m_done_mean [2];
    bit m_pend  [2];

    function automatic int abs_sat(input logic signed [c_dw-1:0] v);
        int x;
        x = int'(v);
        if (x < 0) x = -x;
        if (x > 32767) x = 32767;
        return x;
    endfunction

    task automatic model_clear(input int k);
        m_state[k] = 0; m_step[k] = 0; m_berr[k] = 0; m_good[k] = 0;
        m_clken[k] = 0; m_blk[k].delete(); m_pend[k] = 1'b0; m_done_mean[k] = 0;
    endtask

    task automatic model_edge(input int k);
        int sum;
        int half;
        if (!rst_n || stop) begin
            model_clear(k);
        end else if (m_state[k] == 0) begin
            m_clken[k] = 0;
            if (start) begin
                m_state[k] = 1;
                m_step[k]  = int'(mu_init);
                m_good[k]  = 0;
                m_blk[k].delete();
                m_pend[k]  = 1'b0;
            end
        end else begin
            if (m_pend[k]) begin
                m_berr[k] = m_done_mean[k];
                if (m_state[k] == 1) begin
                    if (m_done_mean[k] < int'(thresh)) begin
                        m_good[k]++;
                        half = m_step[k] / 2;
                        m_step[k] = (half < int'(mu_min)) ? int'(mu_min) : half;
                        if (m_good[k] >= conv_blocks[k]) m_state[k] = 2;
                    end else begin
                        m_good[k] = 0;
                    end
                end else if (m_done_mean[k] > 2 * int'(thresh)) begin
                    m_state[k] = 1;
                    m_step[k]  = int'(mu_init);
                    m_good[k]  = 0;
                end
                m_pend[k] = 1'b0;
            end
            m_clken[k] = sample_valid ? 1 : 0;
            if (sample_valid) begin
                m_blk[k].push_back(abs_sat(e));
                if (m_blk[k].size() == c_bl) begin
                    sum = 0;
                    foreach (m_blk[k][i]) sum += m_blk[k][i];
                    m_done_mean[k] = sum / c_bl;
                    m_pend[k] = 1'b1;
                    m_blk[k].delete();
                end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_edge(k);
        if (!rst_n) checking = 1'b1;
        #1;
        if (checking) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("clk_en[%0d]", k), {31'b0, clk_en_v[k]}, m_clken[k]);
                chk($sformatf("adapt_en[%0d]", k), {31'b0, adapt_en_v[k]}, (m_state[k] == 1) ? 1 : 0);
                chk($sformatf("converged[%0d]", k), {31'b0, conv_v[k]}, (m_state[k] == 2) ? 1 : 0);
                chk($sformatf("state[%0d]", k), {30'b0, state_v[k]}, m_state[k]);
                chk($sformatf("step_size[%0d]", k), {16'b0, step_v[k]}, m_step[k] & 32'hFFFF);
                chk($sformatf("block_err[%0d]", k), {16'b0, berr_v[k]}, m_berr[k]);
            end
        end
    end

    task automatic send(input int v);
        sample_valid = 1'b1;
        e = 16'(v);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic send_block(input int v, input bit alt);
        for (int i = 0; i < c_bl; i++) send((alt && (i % 2 == 1)) ? -v : v);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; @(negedge clk); stop = 1'b0;
    endtask

    task automatic rand_e(input int cls);
        int v;
        case (cls)
            0, 1, 2: v = $urandom_range(0, thresh / 2);
            3:       v = $urandom_range(2 * thresh + 1, 3 * thresh + 10);
            4:       v = $urandom_range(thresh, 2 * thresh);
            default: v = int'($urandom_range(0, 65535)) - 32768;
        endcase
        if (cls < 5 && $urandom_range(0, 1) == 1) v = -v;
        e = 16'(v);
    endtask

    initial begin
        int cls;
        int r;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; sample_valid = 1'b0; e = '0;
        mu_init = 16'sh4000; mu_min = 16'sh0800; thresh = 16'd100;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Strobes in IDLE are ignored
        repeat (3) send(7);
        @(negedge clk);
        chk("idle_state", {30'b0, state_v[0]}, 0);
        chk("idle_clk_en", {30'b0, clk_en_v}, 0);
        chk("idle_step", {16'b0, step_v[0]}, 0);

        // Two good blocks freeze the CONV_BLOCKS=2 instance
        pulse_start();
        chk("start_step", {16'b0, step_v[0]}, 32'h4000);
        send_block(10, 1'b1);
        chk("blk1_err", {16'b0, berr_v[0]}, 10);
        chk("blk1_step", {16'b0, step_v[0]}, 32'h2000);
        send_block(10, 1'b1);
        chk("blk2_step", {16'b0, step_v[0]}, 32'h1000);
        chk("blk2_state", {30'b0, state_v[0]}, 2);
        chk("blk2_adapt_en", {31'b0, adapt_en_v[0]}, 0);
        chk("blk2_state_c4", {30'b0, state_v[1]}, 1);
        chk("model_step_c4", m_step[1], 32'h1000);

        // Step floor
        pulse_stop();
        mu_init = 16'sh1000;
        pulse_start();
        repeat (3) send_block(10, 1'b1);
        chk("floor_step", {16'b0, step_v[1]}, 32'h0800);
        chk("floor_state", {30'b0, state_v[1]}, 1);
        chk("model_good_c4", m_good[1], 3);

        // Good, bad, good: no freeze
        pulse_stop();
        mu_init = 16'sh4000;
        pulse_start();
        send_block(10, 1'b1);
        chk("gbg_step1", {16'b0, step_v[0]}, 32'h2000);
        send_block(500, 1'b1);
        chk("gbg_step2", {16'b0, step_v[0]}, 32'h2000);
        send_block(10, 1'b1);
        chk("gbg_step3", {16'b0, step_v[0]}, 32'h1000);
        chk("gbg_state", {30'b0, state_v[0]}, 1);
        chk("model_good_gbg", m_good[0], 1);

        // Retrain from FROZEN, then a moderate block that keeps it frozen
        send_block(10, 1'b1);
        chk("frz_state", {30'b0, state_v[0]}, 2);
        send_block(300, 1'b0);
        chk("retrain_err", {16'b0, berr_v[0]}, 300);
        chk("retrain_state", {30'b0, state_v[0]}, 1);
        chk("retrain_step", {16'b0, step_v[0]}, 32'h4000);
        chk("retrain_conv", {31'b0, conv_v[0]}, 0);
        send_block(10, 1'b1);
        send_block(10, 1'b1);
        send_block(150, 1'b1);
        chk("hold_err", {16'b0, berr_v[0]}, 150);
        chk("hold_state", {30'b0, state_v[0]}, 2);

        // Most negative error saturates
        send_block(-32768, 1'b0);
        chk("sat_err", {16'b0, berr_v[0]}, 32767);

        // Stop mid-block discards partial samples
        pulse_stop();
        pulse_start();
        send(1000); send(1000);
        pulse_stop();
        chk("stop_state", {30'b0, state_v[0]}, 0);
        chk("stop_step", {16'b0, step_v[0]}, 0);
        pulse_start();
        send_block(20, 1'b1);
        chk("restart_err", {16'b0, berr_v[0]}, 20);

        // Reset mid-block
        send(1000); send(1000);
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        chk("rst_state", {30'b0, state_v[0]}, 0);
        chk("rst_err", {16'b0, berr_v[0]}, 0);
        repeat (3) send(9);
        chk("rst_clk_en", {30'b0, clk_en_v}, 0);

        // Randomized traffic
        cls = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 48 == 0) cls = $urandom_range(0, 5);
            r = $urandom_range(0, 999);
            start = (r < 30);
            stop  = (r >= 990);
            rst_n = (r != 500);
            sample_valid = ($urandom_range(0, 1) == 1);
            rand_e(cls);
            @(negedge clk);
            if (stop || !rst_n) begin
                mu_init = 16'($urandom_range(16'h0100, 16'h7FFF));
                mu_min  = 16'($urandom_range(1, int'(mu_init)));
                thresh  = 16'($urandom_range(20, 400));
            end
        end
        start = 1'b0; stop = 1'b0; rst_n = 1'b1; sample_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
